multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing controller that turns the existing MIPS datapath into a multi-cycle machine. It issues per-phase strobes to the PC, the shared instruction/data memory port, the IR, the register file and the ALU input muxes. It also stalls on a memory-ready handshake and counts retired instructions. It replaces the single-cycle Control_Unit in the multi-cycle top level; Alu_Control still consumes its alu_op.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- run  in  1  permits a new instruction fetch; sampled only in FETCH
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory port completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero flag is set
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1  memory strobes
- ir_write  out  1  IR load
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
- alu_op  out  2  00 add, 01 sub, 10 decode funct
- state  out  4  current state encoding
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- instr_count  out  CNT_W  retired instructions

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 are unreachable and return to FETCH.
- Outputs are Moore-decoded from state, except the strobes qualified by run/mem_ready noted below. Every output not listed for a state is 0.
- FETCH: mem_read=run, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=run&mem_ready.
  - Advance to DECODE when run&mem_ready; otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute the branch target). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 / 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - other -> FETCH with illegal_op=1; no instr_done; count unchanged.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- instr_done and the instr_count increment occur together, in:
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB
  - MEM_WRITE only in its mem_ready cycle.
- instr_count wraps from all-ones to 0.

## Timing
- Reset: when rst_n is low at a rising edge, state goes to FETCH and instr_count goes to 0. While rst_n is low, all outputs are forced to 0 combinationally, including mem_read in FETCH.
- Reset mid-instruction aborts the instruction: no instr_done and no partial write strobes after the reset edge.
- Latency with mem_ready held at 1 (FETCH to FETCH):
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- Each cycle mem_ready is low in FETCH/MEM_READ/MEM_WRITE adds one cycle. Strobes stay stable while waiting.
- mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- run=0 in FETCH holds the machine with no memory strobe. Deasserting run mid-instruction does not stop it; the current instruction completes.
- Back-to-back instructions have no bubble: FETCH follows the last state directly.

## Test plan
- Reset: rst_n=0 for 2 cycles with run=1, mem_ready=1 -> state=0, all strobes 0, instr_count=0. After release, mem_read=1 and ir_write=1 in the first cycle.
- Full sequence with mem_ready=1, opcodes R-type, lw, sw, beq, j, addi -> state traces:
  - R-type 0,1,6,7
  - lw 0,1,2,3,4
  - sw 0,1,2,5
  - beq 0,1,8
  - j 0,1,9
  - addi 0,1,10,11
  - Every strobe matches Operation; instr_count=6 and 6 instr_done pulses.
- Stall: lw with mem_ready low for 3 cycles in FETCH and 2 in MEM_READ -> 10 total cycles. ir_write/pc_write pulse only on the ready cycle; mem_read/i_or_d stay stable.
- Illegal opcode 111111 -> DECODE then FETCH, one illegal_op pulse, no instr_done, count unchanged.
- Reset asserted while in MEM_WRITE with mem_ready=0 -> next cycle state=0, mem_write=0, count 0.
- Counter wrap with CNT_W=4: retire 16 R-type instructions -> instr_count returns to 0; run=0 afterwards holds FETCH with mem_read=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath:
// datapath status in, per-phase strobes and bookkeeping out.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, state, instr_done, illegal_op, instr_count
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, state, instr_done, illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: Moore-decoded phase strobes, memory-ready stalls
// and a wrapping retired-instruction counter.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EX   = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e           state_r;
  state_e           next_state_s;
  logic [CNT_W-1:0] count_r;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic [1:0] pc_source_s;
  logic       i_or_d_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       done_s;
  logic       illegal_s;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      count_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (done_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state and per-phase strobe decode
  always_comb begin
    next_state_s    = state_r;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source_s     = 2'b00;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    done_s          = 1'b0;
    illegal_s       = 1'b0;

    case (state_r)
      ST_FETCH: begin
        // PC+4 is computed every fetch cycle; it only lands on the ready cycle
        mem_read_s  = bus.run;
        alu_src_b_s = 2'b01;
        ir_write_s  = bus.run & bus.mem_ready;
        pc_write_s  = bus.run & bus.mem_ready;
        if (bus.run && bus.mem_ready) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      next_state_s = ST_EXECUTE;
          OP_LW, OP_SW:  next_state_s = ST_MEM_ADDR;
          OP_BEQ:        next_state_s = ST_BRANCH;
          OP_J:          next_state_s = ST_JUMP;
          OP_ADDI:       next_state_s = ST_ADDI_EX;
          default: begin
            next_state_s = ST_FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_LW) begin
          next_state_s = ST_MEM_READ;
        end else begin
          next_state_s = ST_MEM_WRITE;
        end
      end
      ST_MEM_READ: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = ST_MEM_WB;
        end else begin
          next_state_s = ST_MEM_READ;
        end
      end
      ST_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        done_s       = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        // The store only retires on the cycle memory accepts it
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
        done_s      = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEM_WRITE;
        end
      end
      ST_EXECUTE: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b10;
        next_state_s = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        done_s       = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
        done_s          = 1'b1;
        next_state_s    = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'b10;
        done_s       = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_ADDI_EX: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        next_state_s = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_write_s  = 1'b1;
        done_s       = 1'b1;
        next_state_s = ST_FETCH;
      end
      default: begin
        next_state_s = ST_FETCH;
      end
    endcase
  end

  // Reset blanks every output immediately, before the reset edge arrives
  assign bus.pc_write      = rst_n & pc_write_s;
  assign bus.pc_write_cond = rst_n & pc_write_cond_s;
  assign bus.pc_source     = rst_n ? pc_source_s : 2'b00;
  assign bus.i_or_d        = rst_n & i_or_d_s;
  assign bus.mem_read      = rst_n & mem_read_s;
  assign bus.mem_write     = rst_n & mem_write_s;
  assign bus.ir_write      = rst_n & ir_write_s;
  assign bus.reg_dst       = rst_n & reg_dst_s;
  assign bus.mem_to_reg    = rst_n & mem_to_reg_s;
  assign bus.reg_write     = rst_n & reg_write_s;
  assign bus.alu_src_a     = rst_n & alu_src_a_s;
  assign bus.alu_src_b     = rst_n ? alu_src_b_s : 2'b00;
  assign bus.alu_op        = rst_n ? alu_op_s : 2'b00;
  assign bus.state         = rst_n ? state_r : 4'd0;
  assign bus.instr_done    = rst_n & done_s;
  assign bus.illegal_op    = rst_n & illegal_s;
  assign bus.instr_count   = rst_n ? count_r : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a trace model pushes per-cycle
// and per-instruction expectations; an independent monitor pops and compares.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic             done;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } done_t;

  obs_t  cyc_q[$];
  done_t done_q[$];
  obs_t  tbl[0:11];
  int    total = 0;
  int    bad = 0;
  int    cyc_no = 0;
  int    model_cnt = 0;

  // Nominal per-phase outputs as listed in the phase descriptions
  task automatic init_tbl();
    for (int i = 0; i < 12; i++) begin
      tbl[i] = '0;
      tbl[i].st = 4'(i);
    end
    tbl[0].alu_src_b  = 2'b01;
    tbl[1].alu_src_b  = 2'b11;
    tbl[2].alu_src_a  = 1'b1;  tbl[2].alu_src_b = 2'b10;
    tbl[3].mem_read   = 1'b1;  tbl[3].i_or_d = 1'b1;
    tbl[4].reg_write  = 1'b1;  tbl[4].mem_to_reg = 1'b1;
    tbl[5].mem_write  = 1'b1;  tbl[5].i_or_d = 1'b1;
    tbl[6].alu_src_a  = 1'b1;  tbl[6].alu_op = 2'b10;
    tbl[7].reg_write  = 1'b1;  tbl[7].reg_dst = 1'b1;
    tbl[8].alu_src_a  = 1'b1;  tbl[8].alu_op = 2'b01;
    tbl[8].pc_write_cond = 1'b1; tbl[8].pc_source = 2'b01;
    tbl[9].pc_write   = 1'b1;  tbl[9].pc_source = 2'b10;
    tbl[10].alu_src_a = 1'b1;  tbl[10].alu_src_b = 2'b10;
    tbl[11].reg_write = 1'b1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st            = bus.state;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.pc_source     = bus.pc_source;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.reg_dst       = bus.reg_dst;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.instr_done    = bus.instr_done;
    o.illegal_op    = bus.illegal_op;
    o.cnt           = bus.instr_count;
    return o;
  endfunction

  // Monitor: per-cycle output check plus completion-pulse scoreboard
  always @(negedge clk) begin
    obs_t  got;
    obs_t  exp;
    done_t dg;
    done_t de;
    cyc_no++;
    if (cyc_q.size() > 0) begin
      exp = cyc_q.pop_front();
      got = sample();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle_%0d outputs: got %h required %h", cyc_no, got, exp);
      end
    end
    if (bus.instr_done === 1'b1 || bus.illegal_op === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL completion_%0d: unexpected done=%b illegal=%b", cyc_no,
                 bus.instr_done, bus.illegal_op);
      end else begin
        de = done_q.pop_front();
        dg.done = bus.instr_done;
        dg.ill  = bus.illegal_op;
        dg.cnt  = bus.instr_count;
        if (dg !== de) begin
          bad++;
          $display("FAIL completion_%0d: got %h required %h", cyc_no, dg, de);
        end
      end
    end
  end

  task automatic reset_cycles(input int n, input logic run_v, input logic rdy_v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n         = 1'b0;
      bus.run       = run_v;
      bus.mem_ready = rdy_v;
      bus.opcode    = 6'($urandom_range(0, 63));
      cyc_q.push_back('0);
    end
    model_cnt = 0;
  endtask

  task automatic idle(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n         = 1'b1;
      bus.run       = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode    = 6'($urandom_range(0, 63));
      e = tbl[0];
      e.cnt = CNT_W'(model_cnt);
      cyc_q.push_back(e);
    end
  endtask

  // One instruction: build its cycle trace from the phase list, then drive it.
  // abort_at > 0 stops driving after that many cycles (reset follows).
  task automatic issue(input logic [5:0] op, input int fs, input int ms, input int abort_at);
    int   ph[$];
    obs_t exps[$];
    logic rdys[$];
    logic runs[$];
    logic [5:0] ops[$];
    obs_t e;
    int   reps;
    int   n;
    bit   ill;
    bit   stall_ph;
    done_t d;
    ill = 1'b0;
    case (op)
      6'b000000: ph = '{0, 1, 6, 7};
      6'b100011: ph = '{0, 1, 2, 3, 4};
      6'b101011: ph = '{0, 1, 2, 5};
      6'b000100: ph = '{0, 1, 8};
      6'b000010: ph = '{0, 1, 9};
      6'b001000: ph = '{0, 1, 10, 11};
      default: begin ph = '{0, 1}; ill = 1'b1; end
    endcase
    foreach (ph[k]) begin
      stall_ph = (ph[k] == 0 || ph[k] == 3 || ph[k] == 5);
      reps = (ph[k] == 0) ? fs + 1 : (ph[k] == 3 || ph[k] == 5) ? ms + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        e = tbl[ph[k]];
        e.cnt = CNT_W'(model_cnt);
        if (ph[k] == 0) begin
          e.mem_read = 1'b1;
          e.ir_write = (r == reps - 1);
          e.pc_write = (r == reps - 1);
        end
        exps.push_back(e);
        rdys.push_back(stall_ph ? (r == reps - 1) : 1'($urandom_range(0, 1)));
        runs.push_back((ph[k] == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        ops.push_back((ph[k] == 0) ? 6'($urandom_range(0, 63)) : op);
      end
    end
    if (ill) exps[exps.size()-1].illegal_op = 1'b1;
    else     exps[exps.size()-1].instr_done = 1'b1;
    n = (abort_at > 0 && abort_at < exps.size()) ? abort_at : exps.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n         = 1'b1;
      bus.run       = runs[i];
      bus.mem_ready = rdys[i];
      bus.opcode    = ops[i];
      cyc_q.push_back(exps[i]);
      if (i == exps.size() - 1) begin
        d.done = !ill;
        d.ill  = ill;
        d.cnt  = CNT_W'(model_cnt);
        done_q.push_back(d);
        if (!ill) model_cnt = (model_cnt + 1) % (1 << CNT_W);
      end
    end
  endtask

  function automatic logic [5:0] pick_op(input int kind);
    logic [5:0] o;
    case (kind)
      0: o = 6'b000000;
      1: o = 6'b100011;
      2: o = 6'b101011;
      3: o = 6'b000100;
      4: o = 6'b000010;
      5: o = 6'b001000;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b000010 || o == 6'b001000)
          o = 6'($urandom_range(0, 63));
      end
    endcase
    return o;
  endfunction

  initial begin
    init_tbl();
    rst_n         = 1'b0;
    bus.run       = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b000000;

    reset_cycles(2, 1'b1, 1'b1);

    // Directed sequence with memory always ready
    issue(6'b000000, 0, 0, 0);
    issue(6'b100011, 0, 0, 0);
    issue(6'b101011, 0, 0, 0);
    issue(6'b000100, 0, 0, 0);
    issue(6'b000010, 0, 0, 0);
    issue(6'b001000, 0, 0, 0);

    // lw stalled 3 cycles in fetch and 2 in the data read
    issue(6'b100011, 3, 2, 0);
    issue(6'b111111, 0, 0, 0);

    // Reset while a store waits on memory
    issue(6'b101011, 0, 3, 4);
    reset_cycles(1, 1'b1, 1'b0);
    idle(2);

    // Counter wrap, then hold with run low
    for (int i = 0; i < 16; i++) issue(6'b000000, 0, 0, 0);
    idle(3);

    // Random traffic with stalls, idles and occasional mid-instruction resets
    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        issue(pick_op($urandom_range(0, 6)), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(1, 3));
        reset_cycles($urandom_range(1, 2), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
      end else if (sel == 1) begin
        idle($urandom_range(1, 3));
      end else begin
        issue(pick_op($urandom_range(0, 6)), $urandom_range(0, 3),
              $urandom_range(0, 3), 0);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (done_q.size() != 0 || cyc_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending completions=%0d cycles=%0d required 0 and 0",
               done_q.size(), cyc_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
